cart_rom_mapper: RTL and testbench
==================================

Name: cart_rom_mapper

Overview:
Parametrised MegaROM address mapper for MSX cartridge slots. It sits between the CPU slot bus and the cartridge ROM BRAM. It holds four 8 KB bank registers and translates CPU addresses into ROM byte addresses for the no-mapper, Konami, Konami SCC, ASCII8 and ASCII16 schemes. It also flags SCC register-window accesses. It generalises the fixed no-mapper offset arithmetic to runtime-selectable banked mapping with any ROM depth.

Parameters:
ADDR_WIDTH, 18, ROM byte-address width (ROM depth 2^ADDR_WIDTH bytes; 13..24 legal)
BANK_BITS, 8, width of each bank register

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  16  CPU address
wr  in  1  CPU write strobe (level, sampled every clk)
SLTSL_n  in  1  slot select, active low
d_from_cpu  in  8  CPU write data
mapper  in  3  0 unknown, 1 nomapper, 2 reserved, 3 konami, 4 konami SCC, 5 ASCII8, 6 ASCII16
offset  in  4  nomapper base, in 4 KB units
rom_mask  in  ADDR_WIDTH  ROM size rounded up to a power of two, minus 1
mem_addr  out  ADDR_WIDTH  ROM byte address (registered)
mem_oe  out  1  ROM data valid for this CPU access (registered)
scc_sel  out  1  access hits the SCC window (registered)

Behaviour:
- Clocking and reset:
  - Single clk domain.
  - Reset is synchronous, active-high. It has priority over all writes.
- Reset values:
  - bank0..3 = 0,1,2,3 for mappers 3/4.
  - bank0..3 = 0 for mappers 5/6.
  - mem_addr=0, mem_oe=0, scc_sel=0.
- Mapper change: a registered copy of mapper is compared each cycle. On any difference, the banks reload the defaults for the new mapper on the next clk. Default reload wins over a write in the same cycle.
- Bank write: a write occurs when wr=1 & SLTSL_n=0 & addr is inside a register window. bank[n] <= d_from_cpu[BANK_BITS-1:0]. Repeated cycles of the same write are idempotent.
  - konami (3): 6000-7FFF→b1, 8000-9FFF→b2, A000-BFFF→b3. b0 is fixed at 0.
  - konami SCC (4): 5000-57FF→b0, 7000-77FF→b1, 9000-97FF→b2, B000-B7FF→b3.
  - ASCII8 (5): 6000-67FF→b0, 6800-6FFF→b1, 7000-77FF→b2, 7800-7FFF→b3.
  - ASCII16 (6): 6000-67FF→b0 (16 KB page at 4000), 7000-77FF→b2 (16 KB page at 8000).
  - Mappers 0/1/2 have no registers.
- Address translation (registered; 1-cycle latency from addr to mem_addr/mem_oe). Uses bank values as they were before any same-cycle write.
  - Mappers 3/4/5: page p = addr[14:13]-2 (4000→0 … A000→3). Result is {bank[p], addr[12:0]}.
  - Mapper 6: {bank[addr[15]?2:0], addr[13:0]}.
  - Mappers 0/1/2: addr - {offset,12'h000}, computed in 17 bits.
  - All results are AND rom_mask, then truncated to ADDR_WIDTH. Oversize bank numbers therefore mirror.
- mem_oe:
  - Asserted only when SLTSL_n=0 and wr=0.
  - Mappers 3-6: also requires addr in 4000-BFFF.
  - Mappers 0-2: also requires addr ≥ base and (addr-base) ≤ rom_mask; no 17-bit borrow allowed.
- scc_sel: 1 when mapper=4, SLTSL_n=0, addr in 9800-9FFF and bank2[5:0]=6'h3F. It is registered alongside mem_addr. mem_oe is forced 0 when scc_sel would be 1.
- Reset mid-access: outputs read 0 on the cycle after reset. No write that was pending at reset is retained.

Decomposition:
- Shared package cart_pkg:
  - mapper encoding constants (MAPPER_NONE … MAPPER_ASCII16).
  - window base constants.
  - SCC enable value 6'h3F.
- Sub-module cart_bank_regs: four bank registers, write decode per mapper, default reload on reset or mapper change.
- The top level holds the translation and output registers.

Test Plan:
- Konami default: mapper=3, reset, read 0xA123 → mem_addr 0x06123 next cycle, mem_oe=1.
- Konami SCC: write 0x3F at 0x9000, read 0x9800 → scc_sel=1, mem_oe=0. Write 0x05 at 0x9000, read 0x8010 → mem_addr 0x0A010.
- ASCII16: write 0x03 at 0x7000, read 0x8001 → mem_addr 0x0C001. Write 0x07 with rom_mask=0x1FFFF, read 0xBFFF → mem_addr 0x1FFFF (mirrored).
- Nomapper: offset=4, rom_mask=0x7FFF, read 0x4000 → mem_addr 0. Read 0x3FFF → mem_oe=0. Read 0xC000 → mem_oe=0.
- Mapper change with simultaneous write: mapper 5→3 in the same cycle as a write 0x09 at 0x6000 → banks 0,1,2,3; read 0x6000 → 0x02000.
- Reset priority: reset=1 together with a write at 0x5000 (mapper 4) → bank0 remains 0; all outputs 0 the next cycle.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared constants for the MSX MegaROM mapper: mapper encodings, register
// window bases and the SCC enable pattern.
package cart_pkg;

   localparam logic [2:0] MAPPER_UNKNOWN = 3'd0;
   localparam logic [2:0] MAPPER_NONE    = 3'd1;
   localparam logic [2:0] MAPPER_RSVD    = 3'd2;
   localparam logic [2:0] MAPPER_KONAMI  = 3'd3;
   localparam logic [2:0] MAPPER_SCC     = 3'd4;
   localparam logic [2:0] MAPPER_ASCII8  = 3'd5;
   localparam logic [2:0] MAPPER_ASCII16 = 3'd6;

   localparam logic [15:0] KONAMI_B1_WIN = 16'h6000;
   localparam logic [15:0] KONAMI_B2_WIN = 16'h8000;
   localparam logic [15:0] KONAMI_B3_WIN = 16'hA000;

   localparam logic [15:0] SCC_B0_WIN    = 16'h5000;
   localparam logic [15:0] SCC_B1_WIN    = 16'h7000;
   localparam logic [15:0] SCC_B2_WIN    = 16'h9000;
   localparam logic [15:0] SCC_B3_WIN    = 16'hB000;
   localparam logic [15:0] SCC_REG_WIN   = 16'h9800;

   localparam logic [15:0] ASCII8_WIN    = 16'h6000;
   localparam logic [15:0] A16_B0_WIN    = 16'h6000;
   localparam logic [15:0] A16_B2_WIN    = 16'h7000;

   localparam logic [5:0]  SCC_ENABLE    = 6'h3F;

endpackage

// File: rtl/cart_bank_regs.sv
// Four 8 KB bank registers with per-mapper write decode; defaults reload on
// reset or whenever the selected mapper changes.
module cart_bank_regs
   import cart_pkg::*;
#(
   parameter int BANK_BITS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2:0]                mapper,
   input  logic [4:0]                addr_hi,
   input  logic                      wr,
   input  logic                      SLTSL_n,
   input  logic [BANK_BITS-1:0]      din,
   output logic [3:0][BANK_BITS-1:0] bank
);

   logic [2:0]                mapper_q;
   logic [3:0][BANK_BITS-1:0] bank_q, bank_d, bank_def;
   logic                      hit;
   logic [1:0]                widx;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bank_def[i] = (mapper == MAPPER_KONAMI || mapper == MAPPER_SCC) ? BANK_BITS'(i) : '0;
      end

      hit  = 1'b0;
      widx = 2'd0;
      case (mapper)
         MAPPER_KONAMI: begin
            if (addr_hi[4:2] == KONAMI_B1_WIN[15:13]) begin hit = 1'b1; widx = 2'd1; end
            else if (addr_hi[4:2] == KONAMI_B2_WIN[15:13]) begin hit = 1'b1; widx = 2'd2; end
            else if (addr_hi[4:2] == KONAMI_B3_WIN[15:13]) begin hit = 1'b1; widx = 2'd3; end
         end
         MAPPER_SCC: begin
            if (addr_hi == SCC_B0_WIN[15:11]) begin hit = 1'b1; widx = 2'd0; end
            else if (addr_hi == SCC_B1_WIN[15:11]) begin hit = 1'b1; widx = 2'd1; end
            else if (addr_hi == SCC_B2_WIN[15:11]) begin hit = 1'b1; widx = 2'd2; end
            else if (addr_hi == SCC_B3_WIN[15:11]) begin hit = 1'b1; widx = 2'd3; end
         end
         MAPPER_ASCII8: begin
            // 6000-7FFF split into four 2 KB windows, one per bank
            if (addr_hi[4:2] == ASCII8_WIN[15:13]) begin hit = 1'b1; widx = addr_hi[1:0]; end
         end
         MAPPER_ASCII16: begin
            if (addr_hi == A16_B0_WIN[15:11]) begin hit = 1'b1; widx = 2'd0; end
            else if (addr_hi == A16_B2_WIN[15:11]) begin hit = 1'b1; widx = 2'd2; end
         end
         default: ;
      endcase

      bank_d = bank_q;
      if (mapper != mapper_q) begin
         bank_d = bank_def;
      end else if (hit && wr && !SLTSL_n) begin
         bank_d[widx] = din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q   <= bank_def;
         mapper_q <= mapper;
      end else begin
         bank_q   <= bank_d;
         mapper_q <= mapper;
      end
   end

   assign bank = bank_q;

endmodule

// File: rtl/cart_rom_mapper.sv
// MSX MegaROM address mapper: translates CPU slot addresses into ROM byte
// addresses for the supported mapper schemes and flags SCC register accesses.
module cart_rom_mapper
   import cart_pkg::*;
#(
   parameter int ADDR_WIDTH = 18,
   parameter int BANK_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           addr,
   input  logic                  wr,
   input  logic                  SLTSL_n,
   input  logic [7:0]            d_from_cpu,
   input  logic [2:0]            mapper,
   input  logic [3:0]            offset,
   input  logic [ADDR_WIDTH-1:0] rom_mask,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_oe,
   output logic                  scc_sel
);

   logic [3:0][BANK_BITS-1:0] bank;
   logic [1:0]                page;
   logic [BANK_BITS-1:0]      bank_pg, bank_16k;
   logic [16:0]               nm_diff;
   logic                      banked, in_win;
   logic [ADDR_WIDTH-1:0]     mem_addr_d, mem_addr_q;
   logic                      mem_oe_d, mem_oe_q, scc_sel_d, scc_sel_q;

   cart_bank_regs #(.BANK_BITS(BANK_BITS)) u_banks (
      .clk     (clk),
      .reset   (reset),
      .mapper  (mapper),
      .addr_hi (addr[15:11]),
      .wr      (wr),
      .SLTSL_n (SLTSL_n),
      .din     (d_from_cpu[BANK_BITS-1:0]),
      .bank    (bank)
   );

   always_comb begin
      page     = addr[14:13] - 2'd2;
      bank_pg  = bank[page];
      bank_16k = addr[15] ? bank[2] : bank[0];
      // 17-bit subtract so a borrow (addr below base) is visible in bit 16
      nm_diff  = {1'b0, addr} - {1'b0, offset, 12'h000};
      banked   = mapper inside {MAPPER_KONAMI, MAPPER_SCC, MAPPER_ASCII8, MAPPER_ASCII16};

      case (mapper)
         MAPPER_ASCII16:
            mem_addr_d = ADDR_WIDTH'({bank_16k, addr[13:0]}) & rom_mask;
         MAPPER_KONAMI, MAPPER_SCC, MAPPER_ASCII8:
            mem_addr_d = ADDR_WIDTH'({bank_pg, addr[12:0]}) & rom_mask;
         default:
            mem_addr_d = ADDR_WIDTH'(nm_diff[15:0]) & rom_mask;
      endcase

      if (banked) begin
         in_win = (addr[15:14] == 2'b01) || (addr[15:14] == 2'b10);
      end else begin
         in_win = !nm_diff[16] && (32'(nm_diff[15:0]) <= 32'(rom_mask));
      end

      scc_sel_d = (mapper == MAPPER_SCC) && !SLTSL_n
                  && (addr[15:11] == SCC_REG_WIN[15:11])
                  && (bank[2][5:0] == SCC_ENABLE);
      mem_oe_d  = !SLTSL_n && !wr && in_win && !scc_sel_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q <= '0;
         mem_oe_q   <= 1'b0;
         scc_sel_q  <= 1'b0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_oe_q   <= mem_oe_d;
         scc_sel_q  <= scc_sel_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_oe   = mem_oe_q;
   assign scc_sel  = scc_sel_q;

endmodule

// File: tb/tb_cart_rom_mapper.sv
// Directed self-checking bench for cart_rom_mapper: one task per scenario,
// inputs driven after the falling edge, outputs sampled on the next falling edge.
module tb_cart_rom_mapper;

   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   addr;
   logic          wr;
   logic          SLTSL_n;
   logic [7:0]    d_from_cpu;
   logic [2:0]    mapper;
   logic [3:0]    offset;
   logic [AW-1:0] rom_mask;
   logic [AW-1:0] mem_addr;
   logic          mem_oe;
   logic          scc_sel;

   int checks = 0;
   int passed = 0;

   cart_rom_mapper #(.ADDR_WIDTH(AW), .BANK_BITS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .wr         (wr),
      .SLTSL_n    (SLTSL_n),
      .d_from_cpu (d_from_cpu),
      .mapper     (mapper),
      .offset     (offset),
      .rom_mask   (rom_mask),
      .mem_addr   (mem_addr),
      .mem_oe     (mem_oe),
      .scc_sel    (scc_sel)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic w, input logic sl,
                        input logic [15:0] a, input logic [7:0] d);
      reset = r; wr = w; SLTSL_n = sl; addr = a; d_from_cpu = d;
      @(negedge clk);
   endtask

   task automatic rd(input logic [15:0] a);
      drive(1'b0, 1'b0, 1'b0, a, 8'h00);
   endtask

   task automatic wrt(input logic [15:0] a, input logic [7:0] d);
      drive(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
   endtask

   task automatic test_reset();
      mapper = 3'd3; offset = 4'd0; rom_mask = 18'h3FFFF;
      drive(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
      drive(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
      checks++; if (mem_addr !== 18'h0) $display("FAIL reset_addr got %h want 0", mem_addr); else passed++;
      checks++; if (mem_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", mem_oe); else passed++;
      checks++; if (scc_sel !== 1'b0) $display("FAIL reset_scc got %b want 0", scc_sel); else passed++;
   endtask

   task automatic test_konami();
      rd(16'hA123);
      checks++; if (mem_addr !== 18'h06123) $display("FAIL kon_a123 got %h want 06123", mem_addr); else passed++;
      checks++; if (mem_oe !== 1'b1) $display("FAIL kon_a123_oe got %b want 1", mem_oe); else passed++;
      rd(16'h4000);
      checks++; if (mem_addr !== 18'h00000 || mem_oe !== 1'b1) $display("FAIL kon_4000 got %h/%b want 00000/1", mem_addr, mem_oe); else passed++;
      rd(16'hC000);
      checks++; if (mem_oe !== 1'b0) $display("FAIL kon_c000_oe got %b want 0", mem_oe); else passed++;
      wrt(16'h8000, 8'h12);
      checks++; if (mem_oe !== 1'b0) $display("FAIL kon_wr_oe got %b want 0", mem_oe); else passed++;
      wrt(16'hA000, 8'h20);
      checks++; if (mem_addr !== 18'h06000) $display("FAIL kon_wr_old_bank got %h want 06000", mem_addr); else passed++;
      wrt(16'h4000, 8'h07);
      rd(16'h8005);
      checks++; if (mem_addr !== 18'h24005) $display("FAIL kon_b2 got %h want 24005", mem_addr); else passed++;
      rd(16'hA001);
      checks++; if (mem_addr !== 18'h00001) $display("FAIL kon_b3 got %h want 00001", mem_addr); else passed++;
      rd(16'h4010);
      checks++; if (mem_addr !== 18'h00010) $display("FAIL kon_b0_fixed got %h want 00010", mem_addr); else passed++;
   endtask

   task automatic test_scc();
      mapper = 3'd4; rom_mask = 18'h3FFFF;
      idle();
      wrt(16'h9000, 8'h3F);
      rd(16'h9800);
      checks++; if (scc_sel !== 1'b1) $display("FAIL scc_sel got %b want 1", scc_sel); else passed++;
      checks++; if (mem_oe !== 1'b0) $display("FAIL scc_oe got %b want 0", mem_oe); else passed++;
      checks++; if (mem_addr !== 18'h3F800) $display("FAIL scc_addr got %h want 3F800", mem_addr); else passed++;
      wrt(16'h9000, 8'h05);
      rd(16'h8010);
      checks++; if (mem_addr !== 18'h0A010 || mem_oe !== 1'b1) $display("FAIL scc_b2 got %h/%b want 0A010/1", mem_addr, mem_oe); else passed++;
      rd(16'h9800);
      checks++; if (scc_sel !== 1'b0 || mem_oe !== 1'b1) $display("FAIL scc_off got %b/%b want 0/1", scc_sel, mem_oe); else passed++;
      wrt(16'h9800, 8'h3F);
      rd(16'h8010);
      checks++; if (mem_addr !== 18'h0A010) $display("FAIL scc_nowin got %h want 0A010", mem_addr); else passed++;
      wrt(16'h5000, 8'h11);
      rd(16'h4000);
      checks++; if (mem_addr !== 18'h22000) $display("FAIL scc_b0 got %h want 22000", mem_addr); else passed++;
      rd(16'h6004);
      checks++; if (mem_addr !== 18'h02004) $display("FAIL scc_b1_dflt got %h want 02004", mem_addr); else passed++;
   endtask

   task automatic test_back_to_back();
      wrt(16'hB000, 8'h06);
      wrt(16'hB000, 8'h06);
      wrt(16'hB000, 8'h06);
      rd(16'hA000);
      checks++; if (mem_addr !== 18'h0C000) $display("FAIL b2b_b3 got %h want 0C000", mem_addr); else passed++;
      rd(16'hA001);
      checks++; if (mem_addr !== 18'h0C001) $display("FAIL b2b_next got %h want 0C001", mem_addr); else passed++;
   endtask

   task automatic test_ascii16();
      mapper = 3'd6; rom_mask = 18'h3FFFF;
      idle();
      wrt(16'h7000, 8'h03);
      rd(16'h8001);
      checks++; if (mem_addr !== 18'h0C001) $display("FAIL a16_8001 got %h want 0C001", mem_addr); else passed++;
      rd(16'h4005);
      checks++; if (mem_addr !== 18'h00005) $display("FAIL a16_b0 got %h want 00005", mem_addr); else passed++;
      wrt(16'h6000, 8'h02);
      rd(16'h5000);
      checks++; if (mem_addr !== 18'h09000) $display("FAIL a16_5000 got %h want 09000", mem_addr); else passed++;
      rom_mask = 18'h1FFFF;
      wrt(16'h7000, 8'h07);
      rd(16'hBFFF);
      checks++; if (mem_addr !== 18'h1FFFF || mem_oe !== 1'b1) $display("FAIL a16_mirror got %h/%b want 1FFFF/1", mem_addr, mem_oe); else passed++;
      wrt(16'h7000, 8'h0B);
      rd(16'h8002);
      checks++; if (mem_addr !== 18'h0C002) $display("FAIL a16_mask got %h want 0C002", mem_addr); else passed++;
   endtask

   task automatic test_nomapper();
      mapper = 3'd1; offset = 4'd4; rom_mask = 18'h07FFF;
      idle();
      rd(16'h4000);
      checks++; if (mem_addr !== 18'h0 || mem_oe !== 1'b1) $display("FAIL nm_4000 got %h/%b want 00000/1", mem_addr, mem_oe); else passed++;
      rd(16'h3FFF);
      checks++; if (mem_oe !== 1'b0) $display("FAIL nm_below got %b want 0", mem_oe); else passed++;
      rd(16'hC000);
      checks++; if (mem_oe !== 1'b0) $display("FAIL nm_above got %b want 0", mem_oe); else passed++;
      rd(16'hBFFF);
      checks++; if (mem_addr !== 18'h07FFF || mem_oe !== 1'b1) $display("FAIL nm_top got %h/%b want 07FFF/1", mem_addr, mem_oe); else passed++;
      offset = 4'd0;
      rd(16'h1234);
      checks++; if (mem_addr !== 18'h01234 || mem_oe !== 1'b1) $display("FAIL nm_off0 got %h/%b want 01234/1", mem_addr, mem_oe); else passed++;
      idle();
      checks++; if (mem_oe !== 1'b0) $display("FAIL nm_unsel got %b want 0", mem_oe); else passed++;
   endtask

   task automatic test_mapper_change();
      mapper = 3'd5; rom_mask = 18'h3FFFF;
      idle();
      wrt(16'h6800, 8'h0A);
      rd(16'h6000);
      checks++; if (mem_addr !== 18'h14000) $display("FAIL a8_b1 got %h want 14000", mem_addr); else passed++;
      rd(16'h8000);
      checks++; if (mem_addr !== 18'h00000) $display("FAIL a8_b2_dflt got %h want 00000", mem_addr); else passed++;
      mapper = 3'd3;
      wrt(16'h6000, 8'h09);
      rd(16'h6000);
      checks++; if (mem_addr !== 18'h02000) $display("FAIL chg_6000 got %h want 02000", mem_addr); else passed++;
      rd(16'hA000);
      checks++; if (mem_addr !== 18'h06000) $display("FAIL chg_a000 got %h want 06000", mem_addr); else passed++;
      rd(16'h8000);
      checks++; if (mem_addr !== 18'h04000) $display("FAIL chg_8000 got %h want 04000", mem_addr); else passed++;
   endtask

   task automatic test_reset_priority();
      mapper = 3'd4; rom_mask = 18'h3FFFF;
      idle();
      rd(16'hA123);
      checks++; if (mem_addr !== 18'h06123 || mem_oe !== 1'b1) $display("FAIL rp_pre got %h/%b want 06123/1", mem_addr, mem_oe); else passed++;
      drive(1'b1, 1'b1, 1'b0, 16'h5000, 8'h44);
      checks++; if (mem_addr !== 18'h0) $display("FAIL rp_addr got %h want 0", mem_addr); else passed++;
      checks++; if (mem_oe !== 1'b0) $display("FAIL rp_oe got %b want 0", mem_oe); else passed++;
      checks++; if (scc_sel !== 1'b0) $display("FAIL rp_scc got %b want 0", scc_sel); else passed++;
      rd(16'h4000);
      checks++; if (mem_addr !== 18'h00000 || mem_oe !== 1'b1) $display("FAIL rp_bank0 got %h/%b want 00000/1", mem_addr, mem_oe); else passed++;
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; SLTSL_n = 1'b1; addr = '0; d_from_cpu = '0;
      mapper = 3'd3; offset = 4'd0; rom_mask = 18'h3FFFF;
      test_reset();
      test_konami();
      test_scc();
      test_back_to_back();
      test_ascii16();
      test_nomapper();
      test_mapper_change();
      test_reset_priority();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
